// File: rtl/onchip_mem_master_pkg.sv
// Shared types for the on-chip RAM test master: FSM states, mode codes, LFSR constants.
// No logic and no latency; MEM_MASTER_LFSR_EN selects which pattern helpers get used.
package onchip_mem_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [1:0] MODE_FILL       = 2'b00;
   localparam logic [1:0] MODE_CHECK      = 2'b01;
   localparam logic [1:0] MODE_FILL_CHECK = 2'b10;

   localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;
   localparam logic [31:0] LFSR_ZERO_SUB = 32'hFFFF_FFFF;

   // Right-shifting Galois form: the bit shifted out selects the tap XOR.
   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
   endfunction

   // An all-zero LFSR state never leaves zero, so it is swapped for all-ones.
   function automatic logic [31:0] lfsr_seed_fix(input logic [31:0] v);
      return (v == 32'h0) ? LFSR_ZERO_SUB : v;
   endfunction

endpackage

// File: rtl/onchip_mem_pattern_gen.sv
// Test-pattern source: load takes the seed, advance steps one word; registered output, no stall.
// MEM_MASTER_LFSR_EN selects a 32-bit Galois LFSR; otherwise the pattern is seed + index.
module onchip_mem_pattern_gen
   import onchip_mem_master_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_seed,
   input  logic              i_advance,
   output logic [DATA_W-1:0] o_pattern
);

   logic [DATA_W-1:0] r_pat;
   logic [DATA_W-1:0] w_load_val;
   logic [DATA_W-1:0] w_next;

`ifdef MEM_MASTER_LFSR_EN
   assign w_load_val = DATA_W'(lfsr_seed_fix(32'(i_seed)));
   assign w_next     = DATA_W'(lfsr_step(32'(r_pat)));
`else
   assign w_load_val = i_seed;
   assign w_next     = r_pat + DATA_W'(1);
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pat <= '0;
      end else if (i_load) begin
         r_pat <= w_load_val;
      end else if (i_advance) begin
         r_pat <= w_next;
      end
   end

   assign o_pattern = r_pat;

endmodule

// File: rtl/onchip_mem_test_master.sv
// Avalon-MM RAM self-test master: fill L words in L cycles, check in L+1; done pulses the cycle after.
// No backpressure (fixed 1-cycle read latency slave); pattern flavour set by MEM_MASTER_LFSR_EN.
module onchip_mem_test_master
   import onchip_mem_master_pkg::*;
#(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [1:0]          i_mode,
   input  logic [ADDR_W-1:0]   i_base_addr,
   input  logic [ADDR_W:0]     i_length,
   input  logic [DATA_W-1:0]   i_seed,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err_flag,
   output logic [ADDR_W-1:0]   o_err_addr,
   output logic [ADDR_W:0]     o_err_count,
   output logic [ADDR_W-1:0]   o_address,
   output logic [DATA_W/8-1:0] o_byteenable,
   output logic                o_chipselect,
   output logic                o_write,
   output logic [DATA_W-1:0]   o_writedata,
   input  logic [DATA_W-1:0]   i_readdata,
   output logic                o_clken
);

   localparam int LW = ADDR_W + 1;

   state_t              r_state;
   logic [1:0]          r_mode;
   logic [ADDR_W-1:0]   r_base;
   logic [LW-1:0]       r_len;
   logic [DATA_W-1:0]   r_seed;
   logic [LW-1:0]       r_index;
   logic                r_pipe_vld;
   logic [DATA_W-1:0]   r_exp_dat;
   logic [ADDR_W-1:0]   r_exp_addr;

   logic                w_last;
   logic                w_start;
   logic                w_reload;
   logic                w_load;
   logic                w_advance;
   logic [DATA_W-1:0]   w_seed;
   logic [DATA_W-1:0]   w_pattern;

   assign w_last    = (r_index == r_len - LW'(1));
   assign w_start   = (r_state == ST_IDLE) && i_start;
   assign w_reload  = (r_state == ST_WRITE) && w_last && (r_mode != MODE_FILL);
   assign w_load    = w_start || w_reload;
   assign w_advance = (r_state == ST_WRITE) || (r_state == ST_READ);
   assign w_seed    = w_start ? i_seed : r_seed;

   onchip_mem_pattern_gen #(.DATA_W(DATA_W)) u_pattern_gen (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_load    (w_load),
      .i_seed    (w_seed),
      .i_advance (w_advance),
      .o_pattern (w_pattern)
   );

   assign o_writedata = w_pattern;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_mode       <= MODE_FILL;
         r_base       <= '0;
         r_len        <= '0;
         r_seed       <= '0;
         r_index      <= '0;
         r_pipe_vld   <= 1'b0;
         r_exp_dat    <= '0;
         r_exp_addr   <= '0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_err_flag   <= 1'b0;
         o_err_addr   <= '0;
         o_err_count  <= '0;
         o_address    <= '0;
         o_byteenable <= '0;
         o_chipselect <= 1'b0;
         o_write      <= 1'b0;
         o_clken      <= 1'b0;
      end else begin
         o_clken    <= 1'b1;
         o_done     <= 1'b0;
         r_pipe_vld <= 1'b0;

         // Word read in the previous cycle is on readdata now; compare against its piped expectation.
         if (r_pipe_vld && (i_readdata != r_exp_dat)) begin
            if (!o_err_flag) begin
               o_err_flag <= 1'b1;
               o_err_addr <= r_exp_addr;
            end
            if (o_err_count != '1) begin
               o_err_count <= o_err_count + LW'(1);
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_mode      <= (i_mode == 2'b11) ? MODE_FILL_CHECK : i_mode;
                  r_base      <= i_base_addr;
                  r_len       <= i_length;
                  r_seed      <= i_seed;
                  r_index     <= '0;
                  o_err_flag  <= 1'b0;
                  o_err_addr  <= '0;
                  o_err_count <= '0;
                  o_busy      <= 1'b1;
                  o_address   <= i_base_addr;
                  // Empty region idles one cycle in DRAIN so done still lands two cycles after start.
                  if (i_length == '0) begin
                     r_state <= ST_DRAIN;
                  end else begin
                     o_chipselect <= 1'b1;
                     o_byteenable <= '1;
                     o_write      <= (i_mode != MODE_CHECK);
                     r_state      <= (i_mode == MODE_CHECK) ? ST_READ : ST_WRITE;
                  end
               end
            end

            ST_WRITE: begin
               if (w_last) begin
                  r_index <= '0;
                  if (r_mode == MODE_FILL) begin
                     r_state      <= ST_DONE;
                     o_busy       <= 1'b0;
                     o_done       <= 1'b1;
                     o_chipselect <= 1'b0;
                     o_byteenable <= '0;
                     o_write      <= 1'b0;
                  end else begin
                     r_state   <= ST_READ;
                     o_write   <= 1'b0;
                     o_address <= r_base;
                  end
               end else begin
                  r_index   <= r_index + LW'(1);
                  o_address <= o_address + ADDR_W'(1);
               end
            end

            ST_READ: begin
               r_pipe_vld <= 1'b1;
               r_exp_dat  <= w_pattern;
               r_exp_addr <= o_address;
               if (w_last) begin
                  r_state      <= ST_DRAIN;
                  o_chipselect <= 1'b0;
                  o_byteenable <= '0;
               end else begin
                  r_index   <= r_index + LW'(1);
                  o_address <= o_address + ADDR_W'(1);
               end
            end

            ST_DRAIN: begin
               r_state <= ST_DONE;
               o_busy  <= 1'b0;
               o_done  <= 1'b1;
            end

            ST_DONE: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_onchip_mem_test_master.sv
// Bench for onchip_mem_test_master: behavioural RAM plus a per-operation expectation model.
// Honours MEM_MASTER_LFSR_EN in its pattern model.
module tb_onchip_mem_test_master;

   localparam int AW    = 11;
   localparam int DW    = 32;
   localparam int LW    = 12;
   localparam int DEPTH = 2048;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic [AW-1:0] base = '0;
   logic [LW-1:0] len = '0;
   logic [DW-1:0] seed = '0;
   logic          busy, done, err_flag, cs, wr, clken;
   logic [AW-1:0] err_addr, addr;
   logic [LW-1:0] err_count;
   logic [3:0]    be;
   logic [DW-1:0] wdata, rdata;

   always #5 clk = ~clk;

   onchip_mem_test_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode),
      .i_base_addr(base), .i_length(len), .i_seed(seed),
      .o_busy(busy), .o_done(done), .o_err_flag(err_flag), .o_err_addr(err_addr),
      .o_err_count(err_count), .o_address(addr), .o_byteenable(be),
      .o_chipselect(cs), .o_write(wr), .o_writedata(wdata),
      .i_readdata(rdata), .o_clken(clken)
   );

   // Single-port RAM with one-cycle read latency and a backdoor write port.
   logic [DW-1:0] ram [DEPTH];
   logic          bd_en = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [DW-1:0] bd_dat = '0;

   always @(posedge clk) begin
      if (bd_en) ram[bd_addr] <= bd_dat;
      else if (clken && cs) begin
         if (wr) ram[addr] <= wdata;
         else    rdata <= ram[addr];
      end
   end

   logic [DW-1:0] exp_mem [DEPTH];
   logic [DW-1:0] pats [DEPTH];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic bd(input int a, input logic [DW-1:0] v);
      bd_en   = 1'b1;
      bd_addr = AW'(a);
      bd_dat  = v;
      exp_mem[a % DEPTH] = v;
      tick();
      bd_en = 1'b0;
   endtask

   task automatic make_pats(input int l, input logic [DW-1:0] sd);
      pats[0] = sd;
`ifdef MEM_MASTER_LFSR_EN
      if (sd == 0) pats[0] = 32'hFFFF_FFFF;
      for (int i = 1; i < l; i++)
         pats[i] = pats[i-1][0] ? ((pats[i-1] >> 1) ^ 32'h8020_0003) : (pats[i-1] >> 1);
`else
      for (int i = 1; i < l; i++) pats[i] = sd + DW'(i);
`endif
   endtask

   // One operation: model the whole bus trace and final error registers, check every cycle.
   task automatic run_op(input logic [1:0] md, input int b, input int l,
                         input logic [DW-1:0] sd, input bit glitch, input string tag);
      int  m;
      bit  wrs, rds;
      int  w, dc, nerr, first;
      m    = (md == 2'd3) ? 2 : int'(md);
      wrs  = (m != 1);
      rds  = (m != 0);
      w    = wrs ? l : 0;
      dc   = (l == 0) ? 2 : ((m == 0) ? l + 1 : w + l + 2);
      nerr = 0;
      first = 0;
      make_pats(l, sd);
      if (wrs) for (int i = 0; i < l; i++) exp_mem[(b + i) % DEPTH] = pats[i];
      if (rds) for (int i = 0; i < l; i++)
         if (exp_mem[(b + i) % DEPTH] !== pats[i]) begin
            if (nerr == 0) first = (b + i) % DEPTH;
            nerr++;
         end

      mode = md; base = AW'(b); len = LW'(l); seed = sd; start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n <= dc + 1; n++) begin
         bit iw, ir, ecs;
         int idx;
         logic [AW-1:0] ea;
         logic [DW-1:0] ed;
         iw  = wrs && (n <= l);
         ir  = rds && (n > w) && (n <= w + l);
         ecs = iw || ir;
         idx = iw ? n - 1 : n - w - 1;
         ea  = ecs ? AW'(b + idx) : '0;
         ed  = '0;
         if (iw) ed = pats[idx];
         chk(tag,
             {busy, done, cs, wr, be, clken, addr & {AW{ecs}}, wdata & {DW{iw}}},
             {n < dc, n == dc, ecs, iw, ecs ? 4'hF : 4'h0, 1'b1, ea, ed});
         if (glitch && n == 2) begin
            start = 1'b1;
            mode  = 2'($urandom);
            base  = AW'($urandom);
            len   = LW'($urandom_range(0, 20));
            seed  = $urandom;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      chk({tag, "_err"}, {err_flag, err_addr, err_count},
          {nerr > 0, AW'(first), LW'(nerr)});
   endtask

   initial begin
      logic [DW-1:0] sd;
      bit saw;
      for (int i = 0; i < DEPTH; i++) bd(i, $urandom);
      chk("reset_state",
          {busy, done, err_flag, err_addr, err_count, addr, be, cs, wr, wdata, clken}, '0);
      reset = 1'b0;
      tick();
      chk("idle_state", {busy, done, err_flag, cs, wr, be, clken}, 10'b0000000001);

      run_op(2'd0, 0, 16, 32'h100, 1'b0, "fill16");
      run_op(2'd1, 0, 16, 32'h100, 1'b0, "check16");
      chk("check16_cnt", err_count, 0);
`ifndef MEM_MASTER_LFSR_EN
      chk("lit_mem0", ram[0], 32'h100);
      chk("lit_mem15", ram[15], 32'h10F);
`endif
      bd(5, 32'hDEAD);
      run_op(2'd1, 0, 16, 32'h100, 1'b0, "check_bad");
      chk("lit_bad", {err_flag, err_addr, err_count}, {1'b1, 11'd5, 12'd1});

      run_op(2'd0, 2046, 4, 32'h500, 1'b0, "wrap");
`ifndef MEM_MASTER_LFSR_EN
      chk("lit_wrap", {ram[2046], ram[2047], ram[0], ram[1]},
          {32'h500, 32'h501, 32'h502, 32'h503});
`endif
      run_op(2'd2, 123, 0, 32'h77, 1'b0, "len0");
      chk("lit_len0", err_flag, 1'b0);

      // Reset while writing index 7 of a 20-word fill.
      sd = $urandom;
      mode = 2'd0; base = AW'(100); len = LW'(20); seed = sd; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      chk("rst_pre", {cs, wr, addr}, {1'b1, 1'b1, 11'd107});
      reset = 1'b1;
      tick();
      chk("rst_mid", {cs, busy, done, clken}, 4'b0000);
      reset = 1'b0;
      saw = 1'b0;
      repeat (5) begin
         tick();
         if (done || busy) saw = 1'b1;
      end
      chk("rst_nodone", saw, 1'b0);
      run_op(2'd0, 100, 20, $urandom, 1'b0, "after_rst");

      run_op(2'd2, 300, 3, 32'h0, 1'b1, "seed0_glitch");
`ifdef MEM_MASTER_LFSR_EN
      chk("lit_lfsr", {ram[300], ram[301], ram[302]},
          {32'hFFFF_FFFF, 32'hFFDF_FFFC, 32'h7FEF_FFFE});
`else
      chk("lit_inc", {ram[300], ram[301], ram[302]}, {32'h0, 32'h1, 32'h2});
`endif

      for (int k = 0; k < 30; k++) begin
         logic [1:0] md;
         int b, l, nc;
         md = 2'($urandom_range(0, 3));
         b  = $urandom_range(0, DEPTH - 1);
         l  = $urandom_range(0, 40);
         nc = $urandom_range(0, 3);
         for (int c = 0; c < nc; c++)
            bd((b + $urandom_range(0, (l > 0) ? l - 1 : 0)) % DEPTH, $urandom);
         run_op(md, b, l, $urandom, 1'($urandom_range(0, 1)), "rand");
      end

      run_op(2'd2, 1000, 2048, $urandom, 1'b0, "full");
      bd(1500, $urandom);
      bd(20, $urandom);
      run_op(2'd3, 1000, 2048, $urandom, 1'b0, "full_recheck");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
